// File: rtl/vrased_pkg.sv
// Shared constants and FSM encoding for the VRASED violation controller.
package vrased_pkg;

   localparam int VIOL_XSTACK     = 0;
   localparam int VIOL_AC         = 1;
   localparam int VIOL_ATOMICITY  = 2;
   localparam int VIOL_DMA_AC     = 3;
   localparam int VIOL_DMA_DETECT = 4;
   localparam int VIOL_DMA_XSTACK = 5;

   localparam int VIOL_W    = 6;
   localparam int ADDR_W    = 16;
   localparam int ENTRY_W   = 38;
   localparam int CAUSE_LSB = 32;
   localparam int PC_LSB    = 16;
   localparam int ADDR_LSB  = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

endpackage

// File: rtl/vrased_log_buf.sv
// Circular violation log with sticky overflow, synchronous clear and a registered read port.
module vrased_log_buf
   import vrased_pkg::*;
#(
   parameter int LOG_DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         wr_en,
   input  logic [ENTRY_W-1:0]           wr_data,
   input  logic                         or_en,
   input  logic [VIOL_W-1:0]            or_cause,
   input  logic                         clr,
   input  logic                         re,
   input  logic [$clog2(LOG_DEPTH)-1:0] rd_addr,
   output logic [ENTRY_W-1:0]           rd_data,
   output logic                         rd_valid,
   output logic [$clog2(LOG_DEPTH):0]   count,
   output logic                         overflow
);

   localparam int AW = $clog2(LOG_DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   FULL    = (AW+1)'(LOG_DEPTH);

   logic [ENTRY_W-1:0] mem_q [LOG_DEPTH];

   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]        count_q, count_d;
   logic               overflow_q, overflow_d;
   logic [ENTRY_W-1:0] rd_data_q, rd_data_d;
   logic               rd_valid_q, rd_valid_d;

   logic [AW-1:0]      base_ptr, newest, rd_idx;
   logic [AW:0]        base_cnt;
   logic               mem_we;
   logic [AW-1:0]      mem_waddr;
   logic [ENTRY_W-1:0] mem_wdata;

   // Clear takes effect before a same-cycle write, so that write lands at slot 0.
   always_comb begin
      base_ptr   = clr ? '0 : wr_ptr_q;
      base_cnt   = clr ? '0 : count_q;
      wr_ptr_d   = base_ptr;
      count_d    = base_cnt;
      overflow_d = clr ? 1'b0 : overflow_q;
      newest     = wr_ptr_q - PTR_ONE;
      mem_we     = 1'b0;
      mem_waddr  = base_ptr;
      mem_wdata  = wr_data;
      if (wr_en) begin
         mem_we   = 1'b1;
         wr_ptr_d = base_ptr + PTR_ONE;
         if (base_cnt == FULL) begin
            overflow_d = 1'b1;
         end else begin
            count_d = base_cnt + CNT_ONE;
         end
      end else if (or_en && !clr) begin
         mem_we    = 1'b1;
         mem_waddr = newest;
         mem_wdata = mem_q[newest] | {or_cause, {(ENTRY_W-VIOL_W){1'b0}}};
      end
   end

   always_comb begin
      rd_idx     = wr_ptr_q - count_q[AW-1:0] + rd_addr;
      rd_valid_d = re;
      rd_data_d  = rd_data_q;
      if (re) begin
         rd_data_d = ({1'b0, rd_addr} < count_q) ? mem_q[rd_idx] : '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Storage is left uninitialised; reads past count are masked instead.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: rtl/vrased_violation_ctrl.sv
// Merges monitor violations into a stretched CPU reset and logs one entry per violation episode.
//   state   | meaning
//   ST_IDLE | no episode; reset follows viol only
//   ST_HOLD | counting out the guaranteed reset length
//   ST_WAIT | hold expired, waiting for viol to drop
module vrased_violation_ctrl
   import vrased_pkg::*;
#(
   parameter int HOLD_CYCLES = 8,
   parameter int LOG_DEPTH   = 16
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [5:0]                   viol,
   input  logic [15:0]                  pc,
   input  logic [15:0]                  data_addr,
   input  logic [15:0]                  dma_addr,
   output logic                         reset,
   input  logic                         re,
   input  logic [$clog2(LOG_DEPTH)-1:0] rd_addr,
   output logic [37:0]                  rd_data,
   output logic                         rd_valid,
   output logic [$clog2(LOG_DEPTH):0]   log_count,
   output logic                         overflow,
   input  logic                         clr_ram
);

   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               viol_any;
   logic               log_wr, log_or;
   logic [ENTRY_W-1:0] entry;

   assign viol_any = |viol;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      log_wr  = 1'b0;
      log_or  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (viol_any) begin
               state_d = ST_HOLD;
               cnt_d   = CNT_LOAD;
               log_wr  = 1'b1;
            end
         end
         ST_HOLD: begin
            log_or = viol_any;
            if (cnt_q == '0) begin
               state_d = viol_any ? ST_WAIT : ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_WAIT: begin
            log_or = viol_any;
            if (!viol_any) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Any DMA-side cause means the faulting address came from the DMA bus.
   always_comb begin
      entry = '0;
      entry[CAUSE_LSB +: VIOL_W] = viol;
      entry[PC_LSB +: ADDR_W]    = pc;
      entry[ADDR_LSB +: ADDR_W]  = (|viol[VIOL_DMA_XSTACK:VIOL_DMA_AC]) ? dma_addr : data_addr;
   end

   assign reset = viol_any | (state_q != ST_IDLE);

   vrased_log_buf #(
      .LOG_DEPTH (LOG_DEPTH)
   ) u_log_buf (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (log_wr),
      .wr_data  (entry),
      .or_en    (log_or),
      .or_cause (viol),
      .clr      (clr_ram),
      .re       (re),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .count    (log_count),
      .overflow (overflow)
   );

endmodule

// File: tb/tb_vrased_violation_ctrl.sv
// Directed scenarios plus a random phase, all checked cycle by cycle against an episode/queue model.
module tb_vrased_violation_ctrl;
   import vrased_pkg::*;

   localparam int HOLD  = 8;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [5:0]  viol = '0;
   logic [15:0] pc = '0, data_addr = '0, dma_addr = '0;
   logic        reset;
   logic        re = 1'b0;
   logic [3:0]  rd_addr = '0;
   logic [37:0] rd_data;
   logic        rd_valid;
   logic [4:0]  log_count;
   logic        overflow;
   logic        clr_ram = 1'b0;

   int errors = 0;
   int checks = 0;
   int rst_cycles = 0;

   // Model: visible log as a queue (index 0 = oldest), plus an episode flag and hold countdown.
   bit [37:0] mq[$];
   bit        m_ovf = 1'b0;
   bit        m_busy = 1'b0;
   int        m_left = 0;
   bit [37:0] m_rd = '0;
   bit        m_rdv = 1'b0;

   always #5 clk = ~clk;

   vrased_violation_ctrl #(
      .HOLD_CYCLES (HOLD),
      .LOG_DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .viol      (viol),
      .pc        (pc),
      .data_addr (data_addr),
      .dma_addr  (dma_addr),
      .reset     (reset),
      .re        (re),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .log_count (log_count),
      .overflow  (overflow),
      .clr_ram   (clr_ram)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit [37:0] ent;
      m_rdv = re;
      if (re) m_rd = (int'(rd_addr) < mq.size()) ? mq[rd_addr] : '0;
      if (clr_ram) begin
         mq.delete();
         m_ovf = 1'b0;
      end
      if (!m_busy) begin
         if (viol != 0) begin
            ent = {viol, pc, (viol[5:3] != 0) ? dma_addr : data_addr};
            if (mq.size() == DEPTH) begin
               void'(mq.pop_front());
               m_ovf = 1'b1;
            end
            mq.push_back(ent);
            m_busy = 1'b1;
            m_left = HOLD;
         end
      end else begin
         if (viol != 0 && !clr_ram && mq.size() > 0)
            mq[mq.size()-1] = mq[mq.size()-1] | {viol, 32'h0};
         if (m_left > 1) m_left--;
         else if (viol == 0) m_busy = 1'b0;
         else m_left = 0;
      end
   endtask

   task automatic cyc(input logic [5:0] v, input logic r, input logic [3:0] ra, input logic c);
      viol = v; re = r; rd_addr = ra; clr_ram = c;
      #3;
      chk("reset", reset, 64'((v != 0) || m_busy));
      if (reset === 1'b1) rst_cycles++;
      @(posedge clk);
      model_edge();
      #1;
      chk("rd_valid", rd_valid, 64'(m_rdv));
      chk("rd_data", rd_data, 64'(m_rd));
      chk("log_count", log_count, 64'(mq.size()));
      chk("overflow", overflow, 64'(m_ovf));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(6'h00, 1'b0, 4'h0, 1'b0);
   endtask

   initial begin
      logic [5:0] cur_v;

      // Power-on reset: outputs cleared, reset still follows viol.
      repeat (2) @(posedge clk);
      #1;
      chk("por_rd_data", rd_data, 64'h0);
      chk("por_rd_valid", rd_valid, 64'h0);
      chk("por_count", log_count, 64'h0);
      chk("por_overflow", overflow, 64'h0);
      chk("por_reset_idle", reset, 64'h0);
      viol = 6'h20;
      #1;
      chk("por_reset_follows_viol", reset, 64'h1);
      viol = 6'h00;
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic detection
      pc = 16'hA010; data_addr = 16'h6A04; dma_addr = 16'hFFFF;
      rst_cycles = 0;
      cyc(6'b000010, 1'b0, 4'h0, 1'b0);
      idle(12);
      chk("basic_pulse_len", 64'(rst_cycles), 64'(HOLD + 1));
      cyc(6'h00, 1'b1, 4'h0, 1'b0);
      chk("basic_entry", rd_data, 64'({6'h02, 16'hA010, 16'h6A04}));
      chk("basic_count", log_count, 64'h1);

      // DMA violation held long enough to reach WAIT
      cyc(6'h00, 1'b0, 4'h0, 1'b1);
      pc = 16'h8000; data_addr = 16'h5555; dma_addr = 16'hA100;
      rst_cycles = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(6'b010000, 1'b0, 4'h0, 1'b0);
         if (i == 12) chk("dma_in_wait", dut.state_q, 64'(ST_WAIT));
      end
      idle(5);
      chk("dma_pulse_covers_viol", 64'(rst_cycles >= 20), 64'h1);
      cyc(6'h00, 1'b1, 4'h0, 1'b0);
      chk("dma_entry", rd_data, 64'({6'h10, 16'h8000, 16'hA100}));

      // Merged causes within one episode
      cyc(6'h00, 1'b0, 4'h0, 1'b1);
      pc = 16'hB000; data_addr = 16'h1234; dma_addr = 16'h0000;
      cyc(6'b000001, 1'b0, 4'h0, 1'b0);
      idle(2);
      cyc(6'b000100, 1'b0, 4'h0, 1'b0);
      idle(10);
      cyc(6'h00, 1'b1, 4'h0, 1'b0);
      chk("merge_entry", rd_data, 64'({6'h05, 16'hB000, 16'h1234}));
      chk("merge_count", log_count, 64'h1);

      // Overflow after 18 episodes
      cyc(6'h00, 1'b0, 4'h0, 1'b1);
      for (int ep = 1; ep <= 18; ep++) begin
         pc = 16'h1000 + 16'(ep);
         data_addr = 16'($urandom);
         dma_addr = 16'($urandom);
         cyc(6'($urandom_range(1, 63)), 1'b0, 4'h0, 1'b0);
         idle(10);
      end
      chk("ovf_count", log_count, 64'd16);
      chk("ovf_flag", overflow, 64'h1);
      cyc(6'h00, 1'b1, 4'd0, 1'b0);
      chk("ovf_idx0_pc", rd_data[31:16], 64'h1003);
      cyc(6'h00, 1'b1, 4'd15, 1'b0);
      chk("ovf_idx15_pc", rd_data[31:16], 64'h1012);

      // Clear coinciding with a new violation
      pc = 16'hC0DE; data_addr = 16'h0101; dma_addr = 16'hD00D;
      cyc(6'b001000, 1'b0, 4'h0, 1'b1);
      idle(10);
      chk("clrwr_count", log_count, 64'h1);
      chk("clrwr_overflow", overflow, 64'h0);
      cyc(6'h00, 1'b1, 4'd0, 1'b0);
      chk("clrwr_idx0", rd_data, 64'({6'h08, 16'hC0DE, 16'hD00D}));
      cyc(6'h00, 1'b1, 4'd1, 1'b0);
      chk("clrwr_idx1_masked", rd_data, 64'h0);

      // Asynchronous reset in the middle of HOLD
      cyc(6'b000001, 1'b0, 4'h0, 1'b0);
      idle(3);
      reset_n = 1'b0;
      viol = 6'h04;
      #1;
      chk("arst_state", dut.state_q, 64'(ST_IDLE));
      chk("arst_cnt", dut.cnt_q, 64'h0);
      chk("arst_count", log_count, 64'h0);
      chk("arst_reset_follows_viol", reset, 64'h1);
      viol = 6'h00;
      #1;
      chk("arst_reset_low", reset, 64'h0);
      chk("arst_overflow", overflow, 64'h0);
      chk("arst_rd_valid", rd_valid, 64'h0);
      chk("arst_rd_data", rd_data, 64'h0);
      mq.delete(); m_ovf = 1'b0; m_busy = 1'b0; m_left = 0; m_rd = '0; m_rdv = 1'b0;
      @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Random phase
      cur_v = '0;
      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(0, 7) == 0)
            cur_v = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
         pc = 16'($urandom);
         data_addr = 16'($urandom);
         dma_addr = 16'($urandom);
         cyc(cur_v, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 39) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vrased_violation_ctrl.md
# vrased_violation_ctrl

Sequences the VRASED system reset and records violation history. It merges the six monitor violation flags (X_stack, AC, atomicity, dma_AC, dma_detect, dma_X_stack) into one CPU reset and stretches that reset to a guaranteed minimum length. It logs each violation episode into a circular buffer with a registered read port, and sits between the monitor instances and the openMSP430 reset input, taking over the plain OR of monitor resets.

## Interface
- HOLD_CYCLES, 8: minimum reset cycles after the detection cycle, ≥1.
- LOG_DEPTH, 16: log entries; power of two, ≥2.
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- viol  in  6  monitor reset flags; bit0 X_stack, 1 AC, 2 atomicity, 3 dma_AC, 4 dma_detect, 5 dma_X_stack.
- pc  in  16  CPU program counter.
- data_addr  in  16  CPU data address.
- dma_addr  in  16  DMA address.
- reset  out  1  reset to CPU core.
- re  in  1  log read strobe.
- rd_addr  in  log2(LOG_DEPTH)  read index; 0 is the oldest valid entry.
- rd_data  out  38  {cause[5:0], pc[15:0], addr[15:0]}.
- rd_valid  out  1  rd_data updated this cycle.
- log_count  out  log2(LOG_DEPTH)+1  valid entries.
- overflow  out  1  sticky; set when an entry is overwritten.
- clr_ram  in  1  synchronous log clear.

## Operation
- FSM states: IDLE, HOLD, WAIT.
- IDLE → HOLD when viol≠0. In the same edge:
  - write an entry: cause=viol, pc=pc.
  - addr=dma_addr if viol[5:3]≠0, else data_addr.
  - load the counter with HOLD_CYCLES−1.
- HOLD: decrement the counter each cycle.
  - At counter 0: go to IDLE if viol=0, else go to WAIT.
- WAIT → IDLE on the first cycle viol=0.
- Violations arriving in HOLD or WAIT do not create new entries. They are ORed into the cause field of the current (newest) entry.
- reset = (viol≠0) | (state≠IDLE). This is combinational on viol, so the CPU is reset in the detection cycle itself.
- Log write when count<LOG_DEPTH: write at wr_ptr, increment wr_ptr, increment count.
- Log write when full: overwrite the oldest entry, increment wr_ptr (wraps mod LOG_DEPTH), keep count, set overflow.
- Read: physical index = (wr_ptr − count + rd_addr) mod LOG_DEPTH.
  - rd_addr ≥ log_count returns 38'h0.
  - Read-during-write to the same slot returns the pre-write contents.
- clr_ram: zeroes count, wr_ptr and overflow.
  - If a new entry is written in the same cycle, the clear applies first and the entry lands at slot 0, giving count=1.
  - A cause-OR update in the same cycle as clr_ram is dropped.

## Timing
- reset_n low: state IDLE, counter 0, wr_ptr 0, count 0, overflow 0, rd_data 0, rd_valid 0.
  - reset still follows viol combinationally while reset_n is low.
- Minimum reset pulse for a single-cycle viol: 1+HOLD_CYCLES cycles.
- Read latency: re at edge N gives rd_data and rd_valid at N+1. rd_valid is high for exactly one cycle per re; back-to-back re is supported.
- Entry and count are visible to a read issued on the cycle after the write edge.
- Storage (flops) is not cleared by reset_n. Reads beyond count are masked to 0, so stale data is never observable.

## Structure
- Package vrased_pkg holds:
  - cause bit indices VIOL_XSTACK…VIOL_DMA_XSTACK.
  - VIOL_W=6, ENTRY_W=38.
  - field offsets CAUSE_LSB=32, PC_LSB=16, ADDR_LSB=0.
  - FSM state encoding.
- Sub-module vrased_log_buf contains the circular buffer, pointers, count, overflow, read path and clear.
- The top level contains the FSM, counter, reset generation and entry formatting.

## Test plan
- Basic detection: viol=6'b000010 for 1 cycle at pc=16'hA010, data_addr=16'h6A04.
  - reset high for 9 cycles.
  - log_count=1.
  - read idx0 → {6'h02,16'hA010,16'h6A04}.
- DMA violation with WAIT: viol=6'b010000 held 20 cycles, dma_addr=16'hA100.
  - reset high for 20 cycles.
  - FSM passes through WAIT.
  - entry addr=16'hA100.
- Merged causes: bit0 at cycle 0, bit2 at cycle 3.
  - one entry with cause=6'h05.
  - log_count=1.
- Overflow: 18 separated episodes.
  - log_count=16, overflow=1.
  - idx0 holds episode 3, idx15 holds episode 18.
- Clear with simultaneous write: clr_ram in the same cycle as a new violation.
  - log_count=1, overflow=0.
  - idx0 = new entry.
  - read idx1 → 0.
- Async reset mid-HOLD: reset_n pulsed low.
  - state IDLE, counters cleared immediately.
  - reset low once viol=0.
